// File: rtl/display_pkg.sv
// Shared display definitions: blank code, scan FSM states and the segment
// patterns the downstream BCD-to-segment decoder uses.
package display_pkg;

  // Code that the decoder turns into an all-off digit
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Segment order {g,f,e,d,c,b,a}, active-high; codes 10..15 are all-off
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    bcd_to_seg = 7'h3F;
      4'd1:    bcd_to_seg = 7'h06;
      4'd2:    bcd_to_seg = 7'h5B;
      4'd3:    bcd_to_seg = 7'h4F;
      4'd4:    bcd_to_seg = 7'h66;
      4'd5:    bcd_to_seg = 7'h6D;
      4'd6:    bcd_to_seg = 7'h7D;
      4'd7:    bcd_to_seg = 7'h07;
      4'd8:    bcd_to_seg = 7'h7F;
      4'd9:    bcd_to_seg = 7'h6F;
      default: bcd_to_seg = SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/lz_mask.sv
// Leading-zero mask: flags zero digits above the most significant non-zero
// digit. Digit 0 is always shown so a zero value still displays "0".
module lz_mask
  import display_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] iActive,
  input  logic                iBlankLZ,
  output logic [DIGITS-1:0]   oMask
);

  logic lead;

  // Walk down from the top digit while still inside the run of leading zeros
  always_comb begin
    oMask = '0;
    lead  = iBlankLZ;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (iActive[4*k +: 4] == 4'd0)) oMask[k] = 1'b1;
      else                                     lead     = 1'b0;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Seven-segment scan controller: double-buffered BCD value, per-digit guard
// gap, and anode drive delayed one cycle to line up with the registered
// decoder output.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter  int DIGITS       = 4,
  parameter  int SLOT_CYCLES  = 50000,
  parameter  int GUARD_CYCLES = 2,
  localparam int IW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [4*DIGITS-1:0] iValue,
  input  logic                iLoad,
  input  logic                iBlankLZ,
  output logic [3:0]          oBCD,
  output logic [DIGITS-1:0]   oAn,
  output logic [IW-1:0]       oDigit,
  output logic                oFrame
);

  localparam int             CW         = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0]  GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0]  SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0]  IDX_LAST   = IW'(DIGITS - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic                pend_q, pend_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [3:0]          bcd_d;
  logic [3:0]          cur_dig;
  logic                cur_mask;
  logic                commit;
  logic [DIGITS-1:0]   mask;

  lz_mask #(.DIGITS(DIGITS)) u_lz_mask (
    .iActive (active_q),
    .iBlankLZ(iBlankLZ),
    .oMask   (mask)
  );

  // First cycle of digit 0's guard: frame boundary, the only point active may change
  assign commit = (state_q == GUARD) && (cnt_q == '0) && (idx_q == '0);

  // Slot sequencing, double-buffer bookkeeping and next output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    case (state_q)
      GUARD: if (cnt_q == GUARD_LAST) state_d = SHOW;
      SHOW: if (cnt_q == SLOT_LAST) begin
        state_d = GUARD;
        cnt_d   = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      default: state_d = GUARD;
    endcase

    shadow_d = iLoad ? iValue : shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (commit) begin
      if (iLoad)       active_d = iValue;
      else if (pend_q) active_d = shadow_q;
      pend_d = 1'b0;
    end else if (iLoad) begin
      pend_d = 1'b1;
    end

    cur_dig  = BCD_BLANK;
    cur_mask = 1'b0;
    an_d     = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_dig  = active_q[4*k +: 4];
        cur_mask = mask[k];
        an_d[k]  = (state_q != SHOW);
      end
    end
    bcd_d = ((state_q == SHOW) && !cur_mask) ? cur_dig : BCD_BLANK;
  end

  // State, buffers and registered outputs; oAn trails oBCD by one stage
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= GUARD;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      an_q     <= '1;
      oAn      <= '1;
      oBCD     <= BCD_BLANK;
      oDigit   <= '0;
      oFrame   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      oAn      <= an_q;
      oBCD     <= bcd_d;
      oDigit   <= idx_q;
      oFrame   <= commit;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with DIGITS=4, SLOT_CYCLES=8, GUARD_CYCLES=2.
// Reference model works from the frame position (cycle number mod 32).
module tb_display_scan_ctrl;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [15:0] iValue;
  logic        iLoad;
  logic        iBlankLZ;
  logic [3:0]  oBCD;
  logic [3:0]  oAn;
  logic [1:0]  oDigit;
  logic        oFrame;

  display_scan_ctrl #(.DIGITS(4), .SLOT_CYCLES(8), .GUARD_CYCLES(2)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iValue(iValue), .iLoad(iLoad),
    .iBlankLZ(iBlankLZ), .oBCD(oBCD), .oAn(oAn), .oDigit(oDigit), .oFrame(oFrame)
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int          n;
  int          cur_t;
  logic [15:0] m_active, m_shadow;
  logic        m_pend;
  logic [3:0]  an_next;
  logic [3:0]  exp_bcd, exp_an;
  logic        exp_frame;
  logic [1:0]  exp_digit;

  wire [10:0] act_vec = {oBCD, oAn, oFrame, oDigit};
  wire [10:0] exp_vec = {exp_bcd, exp_an, exp_frame, exp_digit};

  // Digit as it should look on the display, leading zeros blanked above the top non-zero digit
  function automatic logic [3:0] disp(input logic [15:0] a, input logic b, input int d);
    int h = 0;
    for (int k = 0; k < 4; k++) if (a[4*k +: 4] != 4'd0) h = k;
    return (b && d > h) ? 4'hF : a[4*d +: 4];
  endfunction

  task automatic model_reset();
    n = 0; cur_t = -1; m_active = '0; m_shadow = '0; m_pend = 1'b0; an_next = 4'hF;
  endtask

  // Drive one cycle of input, advance the model across the edge
  task automatic tick(input logic ld, input logic [15:0] v);
    int t, d, o;
    iLoad = ld; iValue = v;
    @(posedge iClk);
    t = n % 32; d = t / 8; o = t % 8;
    exp_frame = (t == 0);
    exp_digit = d[1:0];
    exp_an    = an_next;
    exp_bcd   = (o < 2) ? 4'hF : disp(m_active, iBlankLZ, d);
    an_next   = (o < 2) ? 4'hF : ~(4'b0001 << d);
    if (t == 0) begin
      if (ld)          begin m_active = v; m_shadow = v; end
      else if (m_pend) m_active = m_shadow;
      m_pend = 1'b0;
    end else if (ld) begin
      m_shadow = v; m_pend = 1'b1;
    end
    cur_t = t; n++;
    #1;
    iLoad = 1'b0;
  endtask

  task automatic skip_to(input int t);
    while (cur_t != t) tick(1'b0, 16'h0);
  endtask

  // Record the digit codes shown during the next full frame (digit d at [4d+3:4d])
  task automatic capture_frame(output logic [15:0] seen);
    seen = '0;
    skip_to(31);
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 16'h0);
      if (cur_t % 8 >= 2) seen[4*(cur_t/8) +: 4] = oBCD;
    end
  endtask

  task automatic test_reset();
    int nfr = 0;
    iRst_n = 1'b0; iLoad = 1'b0; iValue = '0; iBlankLZ = 1'b0;
    model_reset();
    repeat (2) @(posedge iClk);
    #2;
    tests++; if (oBCD !== 4'hF)   begin fails++; $display("FAIL reset_bcd got=%h want=f", oBCD); end
    tests++; if (oAn !== 4'hF)    begin fails++; $display("FAIL reset_an got=%b want=1111", oAn); end
    tests++; if (oDigit !== 2'd0) begin fails++; $display("FAIL reset_digit got=%0d want=0", oDigit); end
    tests++; if (oFrame !== 1'b0) begin fails++; $display("FAIL reset_frame got=%b want=0", oFrame); end
    @(negedge iClk); iRst_n = 1'b1;
    for (int k = 0; k < 96; k++) begin
      tick(1'b0, 16'h0);
      nfr += oFrame;
      tests++; if (act_vec !== exp_vec) begin fails++; $display("FAIL startup t=%0d got=%h want=%h", cur_t, act_vec, exp_vec); end
      if (k == 2) begin
        tests++; if (oBCD !== 4'h0) begin fails++; $display("FAIL first_code got=%h want=0", oBCD); end
      end
      if (k == 3) begin
        tests++; if (oAn !== 4'b1110) begin fails++; $display("FAIL first_anode got=%b want=1110", oAn); end
      end
    end
    tests++; if (nfr != 3) begin fails++; $display("FAIL frame_count got=%0d want=3", nfr); end
  endtask

  task automatic test_load_midframe();
    logic [15:0] s;
    iBlankLZ = 1'b1;
    skip_to(12);
    tick(1'b1, 16'h1234);
    while (cur_t != 31) begin
      tick(1'b0, 16'h0);
      tests++; if (act_vec !== exp_vec) begin fails++; $display("FAIL no_tearing t=%0d got=%h want=%h", cur_t, act_vec, exp_vec); end
    end
    capture_frame(s);
    tests++; if (s !== 16'h1234) begin fails++; $display("FAIL load_1234 got=%h want=1234", s); end
  endtask

  task automatic test_lz();
    logic [15:0] s;
    iBlankLZ = 1'b1;
    skip_to(5); tick(1'b1, 16'h0050);
    capture_frame(s);
    tests++; if (s !== 16'hFF50) begin fails++; $display("FAIL lz_0050_on got=%h want=ff50", s); end
    iBlankLZ = 1'b0;
    capture_frame(s);
    tests++; if (s !== 16'h0050) begin fails++; $display("FAIL lz_0050_off got=%h want=0050", s); end
    iBlankLZ = 1'b1;
    skip_to(3); tick(1'b1, 16'h0000);
    capture_frame(s);
    tests++; if (s !== 16'hFFF0) begin fails++; $display("FAIL lz_0000 got=%h want=fff0", s); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    iBlankLZ = 1'b1;
    skip_to(10); tick(1'b1, 16'h1111);
    skip_to(20); tick(1'b1, 16'h2222);
    capture_frame(s);
    tests++; if (s !== 16'h2222) begin fails++; $display("FAIL last_load_wins got=%h want=2222", s); end
    skip_to(15); tick(1'b1, 16'h4444);
    skip_to(31); tick(1'b1, 16'h3333);
    tests++; if (oFrame !== 1'b1) begin fails++; $display("FAIL commit_frame got=%b want=1", oFrame); end
    s = '0;
    while (cur_t != 31) begin
      tick(1'b0, 16'h0);
      if (cur_t % 8 >= 2) s[4*(cur_t/8) +: 4] = oBCD;
      tests++; if (act_vec !== exp_vec) begin fails++; $display("FAIL same_cycle t=%0d got=%h want=%h", cur_t, act_vec, exp_vec); end
    end
    tests++; if (s !== 16'h3333) begin fails++; $display("FAIL same_cycle_load got=%h want=3333", s); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int k = 0; k < 600; k++) begin
      if (k % 40 == 0) iBlankLZ = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++)
        v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      tick(($urandom_range(0, 15) == 0), v);
      tests++; if (act_vec !== exp_vec) begin fails++; $display("FAIL random t=%0d got=%h want=%h", cur_t, act_vec, exp_vec); end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] s;
    iBlankLZ = 1'b1;
    skip_to(3); tick(1'b1, 16'h9876);
    skip_to(19);
    #3 iRst_n = 1'b0;
    #1;
    tests++; if (oBCD !== 4'hF)   begin fails++; $display("FAIL async_bcd got=%h want=f", oBCD); end
    tests++; if (oAn !== 4'hF)    begin fails++; $display("FAIL async_an got=%b want=1111", oAn); end
    tests++; if (oDigit !== 2'd0) begin fails++; $display("FAIL async_digit got=%0d want=0", oDigit); end
    tests++; if (oFrame !== 1'b0) begin fails++; $display("FAIL async_frame got=%b want=0", oFrame); end
    model_reset();
    @(posedge iClk);
    @(negedge iClk); iRst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, 16'h0);
      tests++; if (act_vec !== exp_vec) begin fails++; $display("FAIL post_reset t=%0d got=%h want=%h", cur_t, act_vec, exp_vec); end
    end
    capture_frame(s);
    tests++; if (s !== 16'hFFF0) begin fails++; $display("FAIL active_cleared got=%h want=fff0", s); end
  endtask

  initial begin
    test_reset();
    test_load_midframe();
    test_lz();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case anything stalls
  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
